pl_hazard_unit: RTL
===================

# pl_hazard_unit

Parametrised pipeline hazard unit for the 5-stage RISC pipeline (IF, ID, EX, MEM, WB). It drives PC/IF enables, the ID/EX bubble, branch flush and the EX-stage forwarding selects. Over the current hazard controller it adds:
- configurable register-address width;
- multi-cycle load-use stalls and multi-cycle branch flush;
- a no-forwarding mode;
- saturating stall and flush performance counters.

## Interface
Parameters:
- REG_AW, 2, register address width (2^REG_AW registers)
- LOAD_LAT, 1, stall cycles per load-use hazard (>=1)
- BR_FLUSH, 1, cycles br_clr is held per taken branch (>=1)
- FWD_EN, 1, 1 = forwarding enabled; 0 = all selects 00, RAW resolved by stalling
- CNT_W, 8, performance counter width

Ports:
- clk  in  1  pipeline clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- ra, rb  in  REG_AW  source regs of instruction in IF/ID
- ra_use, rb_use  in  1  instruction in IF/ID reads ra / rb
- id_out_en, id_store_stall  in  1  IF/ID instruction is OUT / store; ra is read directly from the register file
- ra_ID, rb_ID  in  REG_AW  dest/sources of instruction in ID/EX
- wb_reg_en_ID, mem_read  in  1  ID/EX instruction writes a register / is a load
- ra_EX  in  REG_AW; wb_reg_en_EX  in  1  EX/MEM destination and write enable
- ra_MEM  in  REG_AW; wb_reg_en_MEM  in  1  MEM/WB destination and write enable
- br_taken  in  1  branch resolved taken in EX
- cnt_clr  in  1  synchronous clear of both counters
- pc_en, IF_en  out  1  PC / IF-ID register load enables
- ID_stall  out  1  1 = ID/EX loads a bubble (all control fields 0)
- br_clr  out  1  clears IF/ID and ID/EX
- A_dh_sel, B_dh_sel  out  2  00 = ID/EX operand, 01 = wb_data, 10 = ALU_ea
- out_en_master  out  1  out-port write enable
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters

## Operation
States are RUN, LDSTALL and FLUSH, plus a down-counter `cnt` of width clog2(max(LOAD_LAT, BR_FLUSH)+1).

Hazard terms (a register match counts only when the corresponding use/enable bit is 1):
- luh (load-use hazard): mem_read & wb_reg_en_ID & ((ra_use & ra==ra_ID) | (rb_use & rb==ra_ID)).
- drh (direct-read hazard): (id_out_en | id_store_stall) & ra matches a valid dest in ID/EX, EX/MEM or MEM/WB. The register file writes at the end of WB, so decode reads the old value.
- rawh (FWD_EN=0 only): ra or rb (as used) matches any valid dest in ID/EX, EX/MEM or MEM/WB.
- hz = luh | drh | rawh.

RUN:
- If br_taken: br_clr=1, pc_en=1, IF_en=1, ID_stall=0, flush_cnt++. Go to FLUSH with cnt=BR_FLUSH-1 if BR_FLUSH>1, otherwise stay in RUN. Branch has priority over every hazard.
- Else if hz: pc_en=0, IF_en=0, ID_stall=1, stall_cnt++. If luh and LOAD_LAT>1, go to LDSTALL with cnt=LOAD_LAT-1. drh and rawh re-evaluate each cycle with no state change.
- Else: pc_en=1, IF_en=1, ID_stall=0, br_clr=0.

LDSTALL:
- Outputs as the RUN stall case; stall_cnt++ each cycle; cnt decrements each cycle.
- Leave for RUN when cnt reaches 1.
- br_taken forces the FLUSH behaviour and aborts the stall.

FLUSH:
- br_clr=1, pc_en=1, IF_en=1, ID_stall=0; br_taken and hazards are ignored.
- Return to RUN when cnt reaches 1.

Forwarding (FWD_EN=1):
- A_dh_sel = 10 if wb_reg_en_EX & ra_EX==ra_ID; else 01 if wb_reg_en_MEM & ra_MEM==ra_ID; else 00.
- B_dh_sel is the same with rb_ID. EX/MEM has priority over MEM/WB.
- With FWD_EN=0, both selects are constant 00.

Other rules:
- out_en_master = id_out_en & pc_en & ~br_clr. It pulses exactly once per OUT instruction.
- Counters saturate at 2^CNT_W-1. cnt_clr clears both counters; an increment in the same cycle is dropped.

## Timing
- Next-state logic, `cnt` and the counters are registered on the clk rising edge. All control outputs are combinational from state and inputs, so a hazard takes effect in the same cycle it is detected.
- While rst=1: state=RUN, cnt=0, counters=0, br_clr=1, pc_en=0, IF_en=0, ID_stall=0, selects=00, out_en_master=0.
- On the first edge after reset release, pc_en=1 and IF_en=1.
- A load-use hazard costs exactly LOAD_LAT cycles with pc_en=0.
- A taken branch costs exactly BR_FLUSH cycles with br_clr=1.
- Reset asserted mid-LDSTALL or mid-FLUSH returns to RUN immediately (asynchronously).
- A hazard present on the cycle FLUSH ends is evaluated on the next cycle, in RUN.

## Test plan
- Reset: assert rst with random inputs -> br_clr=1, pc_en=0, counters 0. Release -> pc_en=1, IF_en=1, br_clr=0.
- Forwarding: ra_ID=2, ra_EX=2, ra_MEM=2, both enables 1 -> A_dh_sel=10. Drop wb_reg_en_EX -> 01. rb_ID=1 unmatched -> B_dh_sel=00.
- Load-use, LOAD_LAT=3: mem_read=1, wb_reg_en_ID=1, ra_ID=1, rb=1, rb_use=1 -> pc_en=0, IF_en=0, ID_stall=1 for exactly 3 cycles; stall_cnt=3.
- Branch beats load-use, BR_FLUSH=2: br_taken=1 together with a luh -> br_clr=1 for 2 cycles, pc_en=1, ID_stall=0; flush_cnt=1, stall_cnt unchanged.
- OUT hazard: id_out_en=1, ra=3, ra_EX=3, wb_reg_en_EX=1 -> out_en_master=0, pc_en=0. Clear the match next cycle -> out_en_master=1 for exactly one cycle.
- FWD_EN=0, CNT_W=2: RAW match on rb vs ra_MEM -> stall while matched, selects stay 00. Six stall cycles -> stall_cnt saturates at 3; cnt_clr -> 0.

Source files
------------

// File: rtl/pl_hazard_unit_if.sv
// Hazard-unit bus: pipeline-side register/enable taps in, stage control and counters out.
// The pipeline side uses master; the hazard unit uses slave.
interface pl_hazard_unit_if #(
  parameter int unsigned REG_AW = 2,
  parameter int unsigned CNT_W  = 8
);
  logic [REG_AW-1:0] ra;
  logic [REG_AW-1:0] rb;
  logic              ra_use;
  logic              rb_use;
  logic              id_out_en;
  logic              id_store_stall;
  logic [REG_AW-1:0] ra_ID;
  logic [REG_AW-1:0] rb_ID;
  logic              wb_reg_en_ID;
  logic              mem_read;
  logic [REG_AW-1:0] ra_EX;
  logic              wb_reg_en_EX;
  logic [REG_AW-1:0] ra_MEM;
  logic              wb_reg_en_MEM;
  logic              br_taken;
  logic              cnt_clr;
  logic              pc_en;
  logic              IF_en;
  logic              ID_stall;
  logic              br_clr;
  logic [1:0]        A_dh_sel;
  logic [1:0]        B_dh_sel;
  logic              out_en_master;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output ra, rb, ra_use, rb_use, id_out_en, id_store_stall,
    output ra_ID, rb_ID, wb_reg_en_ID, mem_read,
    output ra_EX, wb_reg_en_EX, ra_MEM, wb_reg_en_MEM,
    output br_taken, cnt_clr,
    input  pc_en, IF_en, ID_stall, br_clr, A_dh_sel, B_dh_sel,
    input  out_en_master, stall_cnt, flush_cnt
  );

  modport slave (
    input  ra, rb, ra_use, rb_use, id_out_en, id_store_stall,
    input  ra_ID, rb_ID, wb_reg_en_ID, mem_read,
    input  ra_EX, wb_reg_en_EX, ra_MEM, wb_reg_en_MEM,
    input  br_taken, cnt_clr,
    output pc_en, IF_en, ID_stall, br_clr, A_dh_sel, B_dh_sel,
    output out_en_master, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pl_hazard_unit.sv
// 5-stage pipeline hazard unit: load-use/direct-read/RAW stalls, multi-cycle branch flush,
// EX-stage forwarding selects and saturating stall/flush counters.
module pl_hazard_unit #(
  parameter int unsigned REG_AW   = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned BR_FLUSH = 1,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned CNT_W    = 8
) (
  input logic           clk,
  input logic           rst,
  pl_hazard_unit_if.slave bus
);

  localparam int unsigned MAX_LAT = (LOAD_LAT > BR_FLUSH) ? LOAD_LAT : BR_FLUSH;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             stall_inc, flush_inc;
  logic             pc_en, if_en, id_stall, br_clr;
  logic [1:0]       a_sel, b_sel;
  logic             luh, drh, rawh, hz;
  logic             ra_dest_hit, rb_dest_hit;

  function automatic logic hit(input logic [REG_AW-1:0] src,
                               input logic [REG_AW-1:0] dst,
                               input logic              dst_en);
    return dst_en && (src == dst);
  endfunction

  // Hazard detection against every in-flight destination not yet written back
  always_comb begin
    ra_dest_hit = hit(bus.ra, bus.ra_ID,  bus.wb_reg_en_ID)
                | hit(bus.ra, bus.ra_EX,  bus.wb_reg_en_EX)
                | hit(bus.ra, bus.ra_MEM, bus.wb_reg_en_MEM);
    rb_dest_hit = hit(bus.rb, bus.ra_ID,  bus.wb_reg_en_ID)
                | hit(bus.rb, bus.ra_EX,  bus.wb_reg_en_EX)
                | hit(bus.rb, bus.ra_MEM, bus.wb_reg_en_MEM);
    luh  = bus.mem_read && bus.wb_reg_en_ID &&
           ((bus.ra_use && (bus.ra == bus.ra_ID)) || (bus.rb_use && (bus.rb == bus.ra_ID)));
    drh  = (bus.id_out_en || bus.id_store_stall) && ra_dest_hit;
    rawh = (FWD_EN == 0) && ((bus.ra_use && ra_dest_hit) || (bus.rb_use && rb_dest_hit));
    hz   = luh || drh || rawh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and stage controls; a taken branch outranks any hazard
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_en     = 1'b1;
    if_en     = 1'b1;
    id_stall  = 1'b0;
    br_clr    = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    case (state)
      RUN, LDSTALL: begin
        if (bus.br_taken) begin
          br_clr    = 1'b1;
          flush_inc = 1'b1;
          if (BR_FLUSH > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = CW'(BR_FLUSH - 1);
          end else begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end else if (state == LDSTALL || hz) begin
          pc_en     = 1'b0;
          if_en     = 1'b0;
          id_stall  = 1'b1;
          stall_inc = 1'b1;
          if (state == LDSTALL) begin
            if (cnt <= CW'(1)) begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - CW'(1);
            end
          end else if (luh && (LOAD_LAT > 1)) begin
            state_nxt = LDSTALL;
            cnt_nxt   = CW'(LOAD_LAT - 1);
          end
        end
      end
      FLUSH: begin
        br_clr = 1'b1;
        if (cnt <= CW'(1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase

    if (rst) begin
      pc_en     = 1'b0;
      if_en     = 1'b0;
      id_stall  = 1'b0;
      br_clr    = 1'b1;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end
  end

  // EX-stage forwarding, EX/MEM result preferred over MEM/WB
  always_comb begin
    a_sel = 2'b00;
    b_sel = 2'b00;
    if ((FWD_EN != 0) && !rst) begin
      if (hit(bus.ra_ID, bus.ra_EX, bus.wb_reg_en_EX))        a_sel = 2'b10;
      else if (hit(bus.ra_ID, bus.ra_MEM, bus.wb_reg_en_MEM)) a_sel = 2'b01;
      if (hit(bus.rb_ID, bus.ra_EX, bus.wb_reg_en_EX))        b_sel = 2'b10;
      else if (hit(bus.rb_ID, bus.ra_MEM, bus.wb_reg_en_MEM)) b_sel = 2'b01;
    end
  end

  // Saturating counters; a clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_en         = pc_en;
  assign bus.IF_en         = if_en;
  assign bus.ID_stall      = id_stall;
  assign bus.br_clr        = br_clr;
  assign bus.A_dh_sel      = a_sel;
  assign bus.B_dh_sel      = b_sel;
  assign bus.out_en_master = bus.id_out_en && pc_en && !br_clr;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.flush_cnt     = flush_cnt;

endmodule
